// File: rtl/compound_out_arbiter_if.sv
// Requester and compound-output signals of compound_out_arbiter.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface compound_out_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int X_WIDTH = 32,
   parameter int SRC_W   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ-1:0]         req_mode;
   logic [NUM_REQ*X_WIDTH-1:0] req_x;
   logic [NUM_REQ-1:0]         req_y;
   logic                       b_out_mode;
   logic [X_WIDTH-1:0]         b_out_x;
   logic                       b_out_y;
   logic [SRC_W-1:0]           b_out_src;
   logic                       b_out_notify;
   logic                       b_out_sync;
   logic                       busy;
   logic                       timeout_pulse;

   modport slave (
      input  req_valid, req_mode, req_x, req_y, b_out_sync,
      output req_ready, b_out_mode, b_out_x, b_out_y, b_out_src,
             b_out_notify, busy, timeout_pulse
   );

   modport master (
      output req_valid, req_mode, req_x, req_y, b_out_sync,
      input  req_ready, b_out_mode, b_out_x, b_out_y, b_out_src,
             b_out_notify, busy, timeout_pulse
   );
endinterface

// File: rtl/compound_out_arbiter.sv
// Round-robin arbiter onto one blocking mode/x/y output; grant in cycle N, notify from N+1.
// Offer is held until b_out_sync; ready stays low while offering, watchdog pulses every TIMEOUT stalls.
module compound_out_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int X_WIDTH = 32,
   parameter int TIMEOUT = 256,
   parameter int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   compound_out_arbiter_if.slave bus
);
   localparam logic [0:0] SEC_A = 1'b0;
   localparam logic [0:0] SEC_B = 1'b1;
   localparam int         CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [0:0]         r_section;
   logic [SRC_W-1:0]   r_rr_ptr;
   logic [SRC_W-1:0]   r_src;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic               r_mode;
   logic [X_WIDTH-1:0] r_x;
   logic               r_y;
   logic               r_timeout;

   logic               w_found;
   logic [SRC_W-1:0]   w_grant;
   logic [SRC_W:0]     w_sum;
   logic [NUM_REQ-1:0] w_ready;

   // Scan from the farthest offset down so the nearest valid to rr_ptr wins.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_sum   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(i);
         if (w_sum >= (SRC_W+1)'(NUM_REQ))
            w_sum = w_sum - (SRC_W+1)'(NUM_REQ);
         if (bus.req_valid[w_sum[SRC_W-1:0]]) begin
            w_found = 1'b1;
            w_grant = w_sum[SRC_W-1:0];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (w_found && (r_section == SEC_A) && !rst)
         w_ready[w_grant] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_section  <= SEC_A;
         r_rr_ptr   <= '0;
         r_src      <= '0;
         r_wait_cnt <= '0;
         r_mode     <= 1'b0;
         r_x        <= '0;
         r_y        <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         if (r_section == SEC_A) begin
            if (w_found) begin
               r_mode     <= bus.req_mode[w_grant];
               r_x        <= bus.req_x[w_grant*X_WIDTH +: X_WIDTH];
               r_y        <= bus.req_y[w_grant];
               r_src      <= w_grant;
               r_section  <= SEC_B;
               r_wait_cnt <= '0;
            end
         end else if (bus.b_out_sync) begin
            // Sync beats a coincident timeout; pointer moves past the served source.
            r_section <= SEC_A;
            r_rr_ptr  <= (r_src == SRC_W'(NUM_REQ - 1)) ? '0 : r_src + SRC_W'(1);
         end else if ((TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT - 1))) begin
            r_timeout  <= 1'b1;
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.req_ready     = w_ready;
   assign bus.b_out_mode    = r_mode;
   assign bus.b_out_x       = r_x;
   assign bus.b_out_y       = r_y;
   assign bus.b_out_src     = r_src;
   assign bus.b_out_notify  = r_section;
   assign bus.busy          = r_section;
   assign bus.timeout_pulse = r_timeout;
endmodule

// File: tb/tb_compound_out_arbiter.sv
// Directed bench for compound_out_arbiter: transaction-level model checked every negedge plus literal checks.
module tb_compound_out_arbiter;
   localparam int N  = 4;
   localparam int XW = 32;
   localparam int TO = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   compound_out_arbiter_if #(.NUM_REQ(N), .X_WIDTH(XW)) bus ();

   compound_out_arbiter #(.NUM_REQ(N), .X_WIDTH(XW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic m, input logic [XW-1:0] x, input logic y);
      bus.req_mode[i]         = m;
      bus.req_x[i*XW +: XW]   = x;
      bus.req_y[i]            = y;
   endtask

   // Transaction-level model: offer = pending message, stalls counted since grant.
   int             m_busy;
   int             m_ptr;
   int             m_src;
   int             m_stall;
   int             m_g;
   logic           m_mode;
   logic           m_y;
   logic           m_pulse;
   logic [XW-1:0]  m_x;
   logic [N-1:0]   m_rdy;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy = 0; m_ptr = 0; m_src = 0; m_stall = 0; m_g = -1;
            m_mode = 1'b0; m_y = 1'b0; m_x = '0; m_pulse = 1'b0; m_rdy = '0;
         end else begin
            m_g = -1;
            if (m_busy == 0)
               for (int k = 0; k < N; k++)
                  if (m_g < 0 && bus.req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            m_rdy = (m_g >= 0) ? (N'(1) << m_g) : '0;
         end
         check("m_ready",  bus.req_ready,     m_rdy);
         check("m_notify", bus.b_out_notify,  m_busy);
         check("m_busy",   bus.busy,          m_busy);
         check("m_mode",   bus.b_out_mode,    m_mode);
         check("m_x",      bus.b_out_x,       m_x);
         check("m_y",      bus.b_out_y,       m_y);
         check("m_src",    bus.b_out_src,     m_src);
         check("m_pulse",  bus.timeout_pulse, m_pulse);
         if (!rst) begin
            m_pulse = 1'b0;
            if (m_g >= 0) begin
               m_busy = 1; m_src = m_g; m_stall = 0;
               m_mode = bus.req_mode[m_g];
               m_x    = bus.req_x[m_g*XW +: XW];
               m_y    = bus.req_y[m_g];
            end else if (m_busy != 0 && bus.b_out_sync) begin
               m_busy = 0;
               m_ptr  = (m_src + 1) % N;
            end else if (m_busy != 0) begin
               m_stall++;
               if (TO != 0 && (m_stall % TO) == 0) m_pulse = 1'b1;
            end
         end
      end
   end

   int          order[$];
   int          exp_order[5];
   logic [10:0] pmask;
   int          npulse;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_order = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      bus.req_valid = '0; bus.req_mode = '0; bus.req_x = '0; bus.req_y = '0;
      bus.b_out_sync = 1'b0;
      repeat (2) tick();
      bus.req_valid = 4'b1111;
      @(negedge clk);
      check("rst_ready",  bus.req_ready,    4'b0000);
      check("rst_notify", bus.b_out_notify, 1'b0);
      check("rst_pulse",  bus.timeout_pulse, 1'b0);
      tick();
      rst = 1'b0;
      bus.req_valid = '0;

      // Single grant to lane 2 and a 5-cycle stall before sync.
      set_lane(2, 1'b1, 32'h55, 1'b1);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      check("t1_ready", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      check("t1_notify", bus.b_out_notify, 1'b1);
      check("t1_x",      bus.b_out_x,      32'h55);
      check("t1_mode",   bus.b_out_mode,   1'b1);
      check("t1_y",      bus.b_out_y,      1'b1);
      check("t1_src",    bus.b_out_src,    2);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check("t1_hold_x", bus.b_out_x,      32'h55);
         check("t1_hold_n", bus.b_out_notify, 1'b1);
      end
      tick();
      bus.b_out_sync = 1'b1;
      @(negedge clk);
      check("t1_sync_n", bus.b_out_notify, 1'b1);
      tick();
      bus.b_out_sync = 1'b0;
      @(negedge clk);
      check("t1_done_n", bus.b_out_notify, 1'b0);
      check("t1_done_b", bus.busy,         1'b0);
      check("t1_keep_x", bus.b_out_x,      32'h55);

      // Reset during an offer, with all lanes pending.
      tick();
      set_lane(1, 1'b0, 32'h77, 1'b0);
      bus.req_valid = 4'b0010;
      @(negedge clk);
      check("t5_ready", bus.req_ready, 4'b0010);
      tick();
      for (int i = 0; i < N; i++) set_lane(i, i[0], 32'h100 + i, ~i[0]);
      bus.req_valid = 4'b1111;
      @(negedge clk);
      check("t5_src", bus.b_out_src, 1);
      tick();
      rst = 1'b1;
      #1;
      check("t5_rst_notify", bus.b_out_notify, 1'b0);
      check("t5_rst_x",      bus.b_out_x,      32'h0);
      check("t5_rst_src",    bus.b_out_src,    0);
      check("t5_rst_ready",  bus.req_ready,    4'b0000);
      tick();
      rst = 1'b0;
      bus.b_out_sync = 1'b1;

      // Round robin with all valids held and sync tied high.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.b_out_notify) order.push_back(int'(bus.b_out_src));
         tick();
      end
      check("rr_count", order.size(), 5);
      for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", order[i], exp_order[i]);
      bus.req_valid = '0;
      bus.b_out_sync = 1'b0;

      // Watchdog: 11 stalled cycles, then sync while the counter is at its limit.
      set_lane(1, 1'b1, 32'hABCD0001, 1'b0);
      bus.req_valid = 4'b0010;
      @(negedge clk);
      check("to_ready", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = '0;
      pmask = '0;
      npulse = 0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (bus.timeout_pulse) begin
            pmask[i] = 1'b1;
            npulse++;
         end
         check("to_offer", bus.b_out_notify, 1'b1);
         tick();
      end
      check("to_mask",   pmask,       11'h110);
      check("to_npulse", npulse,      2);
      check("to_x",      bus.b_out_x, 32'hABCD0001);
      bus.b_out_sync = 1'b1;
      @(negedge clk);
      check("to_sync_pulse", bus.timeout_pulse, 1'b0);
      tick();
      bus.b_out_sync = 1'b0;
      @(negedge clk);
      check("to_sync_wins", bus.timeout_pulse, 1'b0);
      check("to_done",      bus.b_out_notify,  1'b0);

      // Stray sync while idle must not move the pointer (now 2).
      tick();
      bus.b_out_sync = 1'b1;
      @(negedge clk);
      check("ss_notify", bus.b_out_notify, 1'b0);
      tick();
      bus.b_out_sync = 1'b0;
      bus.req_valid = 4'b0111;
      @(negedge clk);
      check("ss_ready", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      check("ss_src", bus.b_out_src, 2);
      tick();
      bus.b_out_sync = 1'b1;
      tick();
      bus.b_out_sync = 1'b0;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
